// File: rtl/dram_pkg.sv
// Shared types and constants for the DRAM-side responder.
package dram_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 18;
    localparam int RD_LAT     = 2;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    typedef struct packed {
        addr_t addr;
        data_t data;
    } wr_entry_t;

    // One stage of the read response pipeline; fwd selects buffer data over SRAM data.
    typedef struct packed {
        logic  valid;
        logic  fwd;
        data_t data;
    } rsp_stage_t;

    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_READ,
        ACC_WRITE
    } acc_kind_e;

endpackage

// File: rtl/dram_resp_if.sv
// Layer-side request/response bus between a layer engine and the DRAM responder.
interface dram_resp_if;
    import dram_pkg::*;

    logic  dram_en_rd;
    addr_t addr_in;
    logic  dram_en_wr;
    addr_t addr_out;
    data_t data_out;
    logic  dram_ready;
    data_t data_in;
    logic  dram_valid;

    modport master (
        output dram_en_rd, addr_in, dram_en_wr, addr_out, data_out,
        input  dram_ready, data_in, dram_valid
    );

    modport slave (
        input  dram_en_rd, addr_in, dram_en_wr, addr_out, data_out,
        output dram_ready, data_in, dram_valid
    );

endinterface

// File: rtl/dram_wr_fifo.sv
// Posted-write circular buffer with a parallel address search for read forwarding.
module dram_wr_fifo
    import dram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wr_entry_t push_entry,
    input  logic      pop,
    output wr_entry_t head,
    output logic      full,
    output logic      empty,
    input  addr_t     search_addr,
    output logic      hit,
    output data_t     hit_data
);

    localparam int PTR_W = $clog2(DEPTH);
    typedef logic [PTR_W-1:0] ptr_t;

    wr_entry_t      store [DEPTH];
    ptr_t           wr_ptr;
    ptr_t           rd_ptr;
    logic [PTR_W:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; count and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= push_entry;
    end

    assign head  = store[rd_ptr];
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);

    // Walk oldest to newest so the last match wins.
    // NOTE: outputs get defaults first so no path through the block infers a latch.
    always_comb begin
        ptr_t idx;
        hit      = 1'b0;
        hit_data = '0;
        idx      = rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + ptr_t'(i);
            if (i < int'(count) && store[idx].addr == search_addr) begin
                hit      = 1'b1;
                hit_data = store[idx].data;
            end
        end
    end

endmodule

// File: rtl/dram_resp.sv
// DRAM responder: arbitrates posted writes and reads onto one SRAM port, returns reads at fixed latency.
module dram_resp
    import dram_pkg::*;
#(
    parameter int WF_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    dram_resp_if.slave       bus,
    output logic             idle,
    output logic             mem_cen,
    output logic             mem_wen,
    output addr_t            mem_addr,
    output data_t            mem_wdata,
    input  data_t            mem_rdata
);

    logic       rd_acc;
    logic       wr_acc;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_hit;
    logic       fifo_pop;
    data_t      fifo_hit_data;
    wr_entry_t  fifo_head;
    acc_kind_e  acc;
    rsp_stage_t pipe [RD_LAT];
    rsp_stage_t resp;
    data_t      rsp_data;
    data_t      data_hold;
    logic       pipe_busy;

    assign bus.dram_ready = ~fifo_full;
    assign rd_acc         = bus.dram_en_rd & ~fifo_full;
    assign wr_acc         = bus.dram_en_wr & ~fifo_full;

    // Search sees start-of-cycle contents, so a same-cycle write never feeds its paired read.
    dram_wr_fifo #(.DEPTH(WF_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (wr_acc),
        .push_entry  ('{addr: bus.addr_out, data: bus.data_out}),
        .pop         (fifo_pop),
        .head        (fifo_head),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .search_addr (bus.addr_in),
        .hit         (fifo_hit),
        .hit_data    (fifo_hit_data)
    );

    // A full buffer must drain first; otherwise reads win over opportunistic drains.
    always_comb begin
        acc      = ACC_NONE;
        fifo_pop = 1'b0;
        if (fifo_full) begin
            acc      = ACC_WRITE;
            fifo_pop = 1'b1;
        end else if (rd_acc && !fifo_hit) begin
            acc = ACC_READ;
        end else if (!fifo_empty) begin
            acc      = ACC_WRITE;
            fifo_pop = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_cen   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_cen <= (acc != ACC_NONE);
            mem_wen <= (acc == ACC_WRITE);
            case (acc)
                ACC_WRITE: begin
                    mem_addr  <= fifo_head.addr;
                    mem_wdata <= fifo_head.data;
                end
                ACC_READ:  mem_addr <= bus.addr_in;
                default:   ;
            endcase
        end
    end

    // Forwarded reads ride the same pipeline so both paths answer at RD_LAT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{valid: rd_acc, fwd: rd_acc & fifo_hit, data: fifo_hit_data};
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign resp           = pipe[RD_LAT-1];
    assign rsp_data       = resp.fwd ? resp.data : mem_rdata;
    assign bus.dram_valid = resp.valid;
    assign bus.data_in    = resp.valid ? rsp_data : data_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             data_hold <= '0;
        else if (resp.valid) data_hold <= rsp_data;
    end

    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < RD_LAT; i++) pipe_busy = pipe_busy | pipe[i].valid;
    end

    assign idle = fifo_empty & ~pipe_busy & ~mem_cen;

endmodule

// File: tb/tb_dram_resp.sv
// Directed self-checking bench for dram_resp with a behavioural single-port SRAM.
module tb_dram_resp;
    import dram_pkg::*;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  idle, mem_cen, mem_wen;
    addr_t mem_addr;
    data_t mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dram_resp_if bus ();

    dram_resp #(.WF_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .idle      (idle),
        .mem_cen   (mem_cen),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // SRAM model: 256 words, 1-cycle read, with a preload port used during reset.
    data_t                            sram [256];
    int                               rd_cnt = 0;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] wr_log [$];
    logic                             pl_en = 1'b0;
    logic [7:0]                       pl_addr = '0;
    data_t                            pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) begin
            sram[pl_addr] <= pl_data;
        end else if (mem_cen) begin
            if (mem_wen) begin
                sram[mem_addr[7:0]] <= mem_wdata;
                wr_log.push_back({mem_addr, mem_wdata});
            end else begin
                mem_rdata <= sram[mem_addr[7:0]];
                rd_cnt    <= rd_cnt + 1;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input addr_t ra, input logic wr, input addr_t wa, input data_t wd);
        bus.dram_en_rd = rd;
        bus.addr_in    = ra;
        bus.dram_en_wr = wr;
        bus.addr_out   = wa;
        bus.data_out   = wd;
    endtask

    task automatic bus_quiet();
        drive(1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic poke(input logic [7:0] a, input data_t d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!idle && n < 30) begin
            tick();
            n++;
        end
        check(tag, 64'(idle), 64'd1);
    endtask

    task automatic read_expect(input string tag, input addr_t a, input data_t exp);
        drive(1'b1, a, 1'b0, '0, '0);
        tick();
        bus_quiet();
        check({tag, "_early"}, 64'(bus.dram_valid), 64'd0);
        tick();
        check({tag, "_valid"}, 64'(bus.dram_valid), 64'd1);
        check({tag, "_data"}, 64'(bus.data_in), 64'(exp));
        tick();
        check({tag, "_pulse"}, 64'(bus.dram_valid), 64'd0);
    endtask

    initial begin
        int    base_rd;
        int    base_wr;
        int    cyc;
        int    acc_n;
        int    first_low;
        int    run;
        int    max_run;
        logic  seen;
        data_t got [$];

        bus_quiet();
        tick();
        poke(8'h10, 32'h1234);
        poke(8'h20, 32'h9);
        for (int i = 0; i < 8; i++) poke(8'(8'h40 + i), 32'(32'h100 + i));
        poke(8'h50, 32'h50A);
        poke(8'h51, 32'h51B);
        for (int i = 0; i < 3; i++) poke(8'(8'h60 + i), 32'(32'hDEAD0 + i));

        // Reset state
        check("rst_valid", 64'(bus.dram_valid), 64'd0);
        check("rst_data_in", 64'(bus.data_in), 64'd0);
        check("rst_mem_cen", 64'(mem_cen), 64'd0);
        check("rst_mem_wen", 64'(mem_wen), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_ready", 64'(bus.dram_ready), 64'd1);
        check("rst_idle", 64'(idle), 64'd1);

        // SRAM read path, latency 2
        tick();
        drive(1'b1, 18'h10, 1'b0, '0, '0);
        check("t1_valid_T", 64'(bus.dram_valid), 64'd0);
        tick();
        bus_quiet();
        check("t1_idle_T1", 64'(idle), 64'd0);
        check("t1_valid_T1", 64'(bus.dram_valid), 64'd0);
        check("t1_cen_T1", 64'(mem_cen), 64'd1);
        check("t1_wen_T1", 64'(mem_wen), 64'd0);
        check("t1_addr_T1", 64'(mem_addr), 64'h10);
        tick();
        check("t1_valid_T2", 64'(bus.dram_valid), 64'd1);
        check("t1_data_T2", 64'(bus.data_in), 64'h1234);
        tick();
        check("t1_valid_T3", 64'(bus.dram_valid), 64'd0);
        check("t1_idle_T3", 64'(idle), 64'd1);
        check("t1_hold_T3", 64'(bus.data_in), 64'h1234);

        // Write then read of same address: forwarded
        base_rd = rd_cnt;
        drive(1'b0, '0, 1'b1, 18'h10, 32'hAAAA);
        tick();
        drive(1'b1, 18'h10, 1'b0, '0, '0);
        check("t2_cen_T1", 64'(mem_cen), 64'd0);
        tick();
        bus_quiet();
        check("t2_cen_T2", 64'(mem_cen), 64'd1);
        check("t2_wen_T2", 64'(mem_wen), 64'd1);
        check("t2_addr_T2", 64'(mem_addr), 64'h10);
        check("t2_wdata_T2", 64'(mem_wdata), 64'hAAAA);
        tick();
        check("t2_valid_T3", 64'(bus.dram_valid), 64'd1);
        check("t2_data_T3", 64'(bus.data_in), 64'hAAAA);
        check("t2_cen_T3", 64'(mem_cen), 64'd0);
        check("t2_no_sram_rd", 64'(rd_cnt - base_rd), 64'd0);
        check("t2_sram_val", 64'(sram[8'h10]), 64'hAAAA);

        // Same-cycle read and write: read sees the old value
        drive(1'b1, 18'h20, 1'b1, 18'h20, 32'h5);
        tick();
        bus_quiet();
        tick();
        check("t3_valid", 64'(bus.dram_valid), 64'd1);
        check("t3_old", 64'(bus.data_in), 64'h9);
        wait_idle("t3_idle");
        read_expect("t3_new", 18'h20, 32'h5);

        // Streaming rd+wr on distinct addresses until 8 of each accepted
        wait_idle("t4_start_idle");
        base_wr   = wr_log.size();
        cyc       = 0;
        acc_n     = 0;
        first_low = -1;
        run       = 0;
        max_run   = 0;
        while (acc_n < 8 && cyc < 40) begin
            logic accepted;
            drive(1'b1, 18'(18'h40 + acc_n), 1'b1, 18'(18'h80 + acc_n), 32'(32'h200 + acc_n));
            accepted = bus.dram_ready;
            if (!accepted) begin
                if (first_low < 0) first_low = cyc;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            tick();
            if (bus.dram_valid) got.push_back(bus.data_in);
            if (accepted) acc_n++;
            cyc++;
        end
        bus_quiet();
        for (int i = 0; i < 20 && got.size() < 8; i++) begin
            if (i > 0 || 1'b1) begin
                tick();
                if (bus.dram_valid) got.push_back(bus.data_in);
            end
        end
        check("t4_accepted", 64'(acc_n), 64'd8);
        check("t4_first_full", 64'(first_low), 64'd4);
        check("t4_max_low_run", 64'(max_run), 64'd1);
        check("t4_resp_count", 64'(got.size()), 64'd8);
        for (int k = 0; k < 8 && k < got.size(); k++)
            check($sformatf("t4_rd%0d", k), 64'(got[k]), 64'(32'h100 + k));
        wait_idle("t4_drain_idle");
        check("t4_wr_count", 64'(wr_log.size() - base_wr), 64'd8);
        for (int k = 0; k < 8 && base_wr + k < wr_log.size(); k++)
            check($sformatf("t4_wr%0d", k), 64'(wr_log[base_wr + k]),
                  64'({18'(18'h80 + k), 32'(32'h200 + k)}));

        // Two buffered writes to one address, newest wins
        base_rd = rd_cnt;
        drive(1'b1, 18'h50, 1'b1, 18'h30, 32'h1);
        tick();
        drive(1'b1, 18'h51, 1'b1, 18'h30, 32'h2);
        tick();
        check("t5_rd50", 64'(bus.data_in), 64'h50A);
        drive(1'b1, 18'h30, 1'b0, '0, '0);
        tick();
        bus_quiet();
        check("t5_rd51", 64'(bus.data_in), 64'h51B);
        tick();
        check("t5_valid", 64'(bus.dram_valid), 64'd1);
        check("t5_newest", 64'(bus.data_in), 64'h2);
        wait_idle("t5_idle");
        check("t5_sram_rds", 64'(rd_cnt - base_rd), 64'd2);
        check("t5_sram_val", 64'(sram[8'h30]), 64'h2);

        // Async reset with 3 buffered writes and reads in flight
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 18'(18'h70 + i), 1'b1, 18'(18'h60 + i), 32'(32'h300 + i));
            tick();
        end
        bus_quiet();
        check("t6_pre_valid", 64'(bus.dram_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_valid", 64'(bus.dram_valid), 64'd0);
        check("t6_data_in", 64'(bus.data_in), 64'd0);
        check("t6_cen", 64'(mem_cen), 64'd0);
        check("t6_wen", 64'(mem_wen), 64'd0);
        check("t6_addr", 64'(mem_addr), 64'd0);
        check("t6_wdata", 64'(mem_wdata), 64'd0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.dram_valid || mem_cen) seen = 1'b1;
        end
        check("t6_no_activity", 64'(seen), 64'd0);
        check("t6_idle", 64'(idle), 64'd1);
        check("t6_ready", 64'(bus.dram_ready), 64'd1);
        check("t6_discard60", 64'(sram[8'h60]), 64'hDEAD0);
        check("t6_discard62", 64'(sram[8'h62]), 64'hDEAD2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
